rx_frame_receiver_param: RTL and testbench

//  Parametrised serial frame receiver: next generation of the CRC network controller RX path.

---
 rtl/rx_frame_receiver_param.sv | 197 +++++++++++++++++++
 tb/tb_rx_frame_receiver_param.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_receiver_param.sv
`default_nettype none
// ============================================================================
// Module      : rx_frame_receiver_param
// Description : Serial frame receiver - preamble/SFD hunt, header/payload/CRC-8
//               deserialisation, destination filter, valid/ready frame output.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_frame_receiver_param #(
   parameter int         ID_W     = 2,
   parameter int         LEN_W    = 4,
   parameter int         PRE_LEN  = 16,
   parameter logic [7:0] CRC_POLY = 8'h07,
   parameter bit         CRC_HDR  = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rx_line,
   input  logic [ID_W-1:0]           my_id,
   input  logic                      promisc,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ID_W-1:0]           out_dest,
   output logic [ID_W-1:0]           out_src,
   output logic [LEN_W-1:0]          out_len,
   output logic [8*(2**LEN_W)-1:0]   out_payload,
   output logic                      crc_err,
   output logic                      overrun,
   output logic                      filtered
);

   localparam int C_HDR_W = 2*ID_W + LEN_W;
   localparam int C_PAY_W = 8*(2**LEN_W);
   localparam int C_CNT_W = $clog2(C_PAY_W);
   localparam logic [2*PRE_LEN-1:0] C_PRE_DBL  = {PRE_LEN{2'b10}};
   localparam logic [PRE_LEN-1:0]   C_PREAMBLE = C_PRE_DBL[2*PRE_LEN-1:PRE_LEN];
   localparam logic [7:0]           C_SFD      = 8'b1010_1011;
   localparam logic [7:0]           C_SFD_IDLE = 8'b1010_1010;
   localparam logic [C_CNT_W-1:0]   C_CNT_ONE  = C_CNT_W'(1);
   localparam logic [C_CNT_W-1:0]   C_BYTE_END = C_CNT_W'(7);
   localparam logic [C_CNT_W-1:0]   C_HDR_END  = C_CNT_W'(C_HDR_W-1);

   typedef enum logic [2:0] {
      S_HUNT = 3'd0,
      S_SFD  = 3'd1,
      S_HDR  = 3'd2,
      S_PAY  = 3'd3,
      S_CRC  = 3'd4
   } state_t;

   state_t               r_state;
   // Shift registers keep one bit less than the window they match: the oldest
   // bit is only ever needed for the comparison against the next value.
   logic [PRE_LEN-2:0]   r_pre;
   logic [6:0]           r_sfd;
   logic [C_HDR_W-1:0]   r_hdr;
   logic [C_PAY_W-1:0]   r_pay;
   logic [6:0]           r_crc_rx;
   logic [7:0]           r_crc;
   logic [C_CNT_W-1:0]   r_cnt;

   function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
      logic fb;
      fb = c[7] ^ b;
      return {c[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
   endfunction

   logic [PRE_LEN-1:0]   w_pre_next;
   logic [7:0]           w_sfd_next;
   logic [C_HDR_W-1:0]   w_hdr_next;
   logic [C_PAY_W-1:0]   w_pay_next;
   logic [7:0]           w_crc_rx_next;
   logic [7:0]           w_crc_step;
   logic [ID_W-1:0]      w_dest;
   logic [ID_W-1:0]      w_src;
   logic [LEN_W-1:0]     w_len;
   logic [C_CNT_W-1:0]   w_pay_end;
   logic                 w_accept;
   logic                 w_crc_ok;

   assign w_pre_next    = {r_pre, rx_line};
   assign w_sfd_next    = {r_sfd, rx_line};
   assign w_hdr_next    = {r_hdr[C_HDR_W-2:0], rx_line};
   assign w_pay_next    = {r_pay[C_PAY_W-2:0], rx_line};
   assign w_crc_rx_next = {r_crc_rx, rx_line};
   assign w_crc_step    = crc_step(r_crc, rx_line);
   assign w_dest        = r_hdr[C_HDR_W-1 -: ID_W];
   assign w_src         = r_hdr[LEN_W+ID_W-1 -: ID_W];
   assign w_len         = r_hdr[LEN_W-1:0];
   assign w_pay_end     = {w_len, 3'b111};   // (len+1)*8-1
   assign w_accept      = promisc | (w_dest == my_id) | (&w_dest);
   assign w_crc_ok      = (w_crc_rx_next == r_crc);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_HUNT;
         r_pre       <= '0;
         r_sfd       <= '0;
         r_hdr       <= '0;
         r_pay       <= '0;
         r_crc_rx    <= '0;
         r_crc       <= '0;
         r_cnt       <= '0;
         out_valid   <= 1'b0;
         out_dest    <= '0;
         out_src     <= '0;
         out_len     <= '0;
         out_payload <= '0;
         crc_err     <= 1'b0;
         overrun     <= 1'b0;
         filtered    <= 1'b0;
      end else begin
         crc_err  <= 1'b0;
         overrun  <= 1'b0;
         filtered <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         case (r_state)
            S_HUNT: begin
               r_pre <= w_pre_next[PRE_LEN-2:0];
               if (w_pre_next == C_PREAMBLE) begin
                  r_state <= S_SFD;
                  r_sfd   <= '0;
                  r_cnt   <= '0;
               end
            end
            S_SFD: begin
               r_sfd <= w_sfd_next[6:0];
               if (r_cnt != C_BYTE_END) begin
                  r_cnt <= r_cnt + C_CNT_ONE;
               end
               if (w_sfd_next == C_SFD) begin
                  r_state <= S_HDR;
                  r_cnt   <= '0;
                  r_crc   <= 8'h00;
               end else if (r_cnt == C_BYTE_END && w_sfd_next != C_SFD_IDLE) begin
                  // a full byte that is neither SFD nor preamble tail: false lock
                  r_state <= S_HUNT;
                  r_pre   <= '0;
                  r_sfd   <= '0;
               end
            end
            S_HDR: begin
               r_hdr <= w_hdr_next;
               r_cnt <= r_cnt + C_CNT_ONE;
               if (CRC_HDR) begin
                  r_crc <= w_crc_step;
               end
               if (r_cnt == C_HDR_END) begin
                  r_state <= S_PAY;
                  r_cnt   <= '0;
                  r_pay   <= '0;
               end
            end
            S_PAY: begin
               r_pay <= w_pay_next;
               r_crc <= w_crc_step;
               r_cnt <= r_cnt + C_CNT_ONE;
               if (r_cnt == w_pay_end) begin
                  r_state  <= S_CRC;
                  r_cnt    <= '0;
                  r_crc_rx <= '0;
               end
            end
            S_CRC: begin
               r_crc_rx <= w_crc_rx_next[6:0];
               r_cnt    <= r_cnt + C_CNT_ONE;
               if (r_cnt == C_BYTE_END) begin
                  if (!w_crc_ok) begin
                     crc_err <= 1'b1;
                  end else if (!w_accept) begin
                     filtered <= 1'b1;
                  end else if (!out_valid || out_ready) begin
                     out_valid   <= 1'b1;
                     out_dest    <= w_dest;
                     out_src     <= w_src;
                     out_len     <= w_len;
                     out_payload <= r_pay;
                  end else begin
                     overrun <= 1'b1;
                  end
                  r_state <= S_HUNT;
                  r_pre   <= '0;
                  r_sfd   <= '0;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= S_HUNT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_receiver_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_frame_receiver_param
// Description : Directed table-driven bench for rx_frame_receiver_param.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_frame_receiver_param;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         rx_line   = 1'b0;
   logic [1:0]   my_id     = 2'b01;
   logic         promisc   = 1'b0;
   logic         out_ready = 1'b1;
   logic         out_valid;
   logic [1:0]   out_dest;
   logic [1:0]   out_src;
   logic [3:0]   out_len;
   logic [127:0] out_payload;
   logic         crc_err;
   logic         overrun;
   logic         filtered;

   always #5 clk = ~clk;

   rx_frame_receiver_param #(
      .ID_W     (2),
      .LEN_W    (4),
      .PRE_LEN  (16),
      .CRC_POLY (8'h07),
      .CRC_HDR  (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_line     (rx_line),
      .my_id       (my_id),
      .promisc     (promisc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_dest    (out_dest),
      .out_src     (out_src),
      .out_len     (out_len),
      .out_payload (out_payload),
      .crc_err     (crc_err),
      .overrun     (overrun),
      .filtered    (filtered)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cnt_crc = 0;
   int cnt_filt = 0;
   int cnt_ovr = 0;

   always @(negedge clk) begin
      if (crc_err)  cnt_crc++;
      if (filtered) cnt_filt++;
      if (overrun)  cnt_ovr++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] crc_bit(input logic [7:0] c, input logic b);
      return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
   endfunction

   logic fq[$];

   task automatic push_pat(input logic [15:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) fq.push_back(v[i]);
   endtask

   // flip: payload bit index to invert after the CRC is computed (-1 = none)
   task automatic build_frame(input logic [1:0] d, input logic [1:0] s, input logic [3:0] len,
                              input logic [127:0] pay, input int flip);
      logic [7:0] hdr;
      logic [7:0] crc;
      int nb;
      hdr = {d, s, len};
      crc = 8'h00;
      nb  = (int'(len) + 1) * 8;
      fq.delete();
      push_pat(16'hAAAA, 16);
      push_pat(16'h00AB, 8);
      for (int i = 7; i >= 0; i--) begin
         fq.push_back(hdr[i]);
         crc = crc_bit(crc, hdr[i]);
      end
      for (int i = nb - 1; i >= 0; i--) begin
         crc = crc_bit(crc, pay[i]);
         fq.push_back((i == flip) ? ~pay[i] : pay[i]);
      end
      for (int i = 7; i >= 0; i--) fq.push_back(crc[i]);
   endtask

   task automatic send_range(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         @(negedge clk);
         rx_line = fq[i];
      end
   endtask

   task automatic send_all();
      send_range(0, fq.size() - 1);
   endtask

   task automatic idle(input int n);
      rx_line = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      logic [1:0]   dest;
      logic [1:0]   src;
      logic [3:0]   len;
      logic [127:0] pay;
      int           flip;
      logic         prom;
      logic         exp_valid;
      logic         exp_crc;
      logic         exp_filt;
   } vec_t;

   localparam int NV = 10;
   vec_t tbl[NV];

   initial begin
      logic [127:0] rpay;
      int c0;
      int f0;
      int o0;

      tbl[0] = '{2'd1, 2'd2, 4'd3,  128'hDEADBEEF, -1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{2'd1, 2'd2, 4'd3,  128'hDEADBEEF,  5, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{2'd2, 2'd2, 4'd3,  128'hDEADBEEF, -1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{2'd3, 2'd2, 4'd3,  128'hDEADBEEF, -1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{2'd2, 2'd0, 4'd1,  128'hCAFE,     -1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5] = '{2'd0, 2'd3, 4'd0,  128'h5A,       -1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[6] = '{2'd1, 2'd1, 4'd0,  128'h00,       -1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{2'd1, 2'd2, 4'd15, 128'h0123456789ABCDEF_FEDCBA9876543210, -1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{2'd1, 2'd2, 4'd15, 128'h0123456789ABCDEF_FEDCBA9876543210, 127, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9] = '{2'd3, 2'd1, 4'd7,  128'h1122334455667788, 0, 1'b0, 1'b0, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      check("reset out_valid", out_valid, 0);
      check("reset out_payload", out_payload, 0);
      check("reset out_dest", out_dest, 0);
      check("reset pulses", {crc_err, overrun, filtered}, 0);
      rst_n = 1'b1;
      idle(4);

      for (int v = 0; v < NV; v++) begin
         promisc   = tbl[v].prom;
         out_ready = 1'b1;
         build_frame(tbl[v].dest, tbl[v].src, tbl[v].len, tbl[v].pay, tbl[v].flip);
         send_all();
         @(posedge clk); #1;
         rx_line = 1'b0;
         check($sformatf("v%0d out_valid", v), out_valid, tbl[v].exp_valid);
         check($sformatf("v%0d crc_err", v), crc_err, tbl[v].exp_crc);
         check($sformatf("v%0d filtered", v), filtered, tbl[v].exp_filt);
         check($sformatf("v%0d overrun", v), overrun, 0);
         if (tbl[v].exp_valid) begin
            check($sformatf("v%0d out_dest", v), out_dest, tbl[v].dest);
            check($sformatf("v%0d out_src", v), out_src, tbl[v].src);
            check($sformatf("v%0d out_len", v), out_len, tbl[v].len);
            check($sformatf("v%0d out_payload", v), out_payload, tbl[v].pay);
         end
         @(posedge clk); #1;
         check($sformatf("v%0d out_valid consumed", v), out_valid, 0);
         check($sformatf("v%0d pulses one cycle", v), {crc_err, filtered}, 0);
         idle(3);
      end
      promisc = 1'b0;

      // overrun: two back-to-back good frames with consumer stalled
      out_ready = 1'b0;
      o0 = cnt_ovr;
      build_frame(2'd1, 2'd2, 4'd1, 128'h1234, -1);
      send_all();
      @(posedge clk); #1;
      check("ovr first out_valid", out_valid, 1);
      check("ovr first out_payload", out_payload, 128'h1234);
      build_frame(2'd3, 2'd0, 4'd0, 128'hC3, -1);
      send_all();
      @(posedge clk); #1;
      rx_line = 1'b0;
      check("ovr overrun pulse", overrun, 1);
      check("ovr held out_valid", out_valid, 1);
      check("ovr held out_payload", out_payload, 128'h1234);
      check("ovr held dest/src/len", {out_dest, out_src, out_len}, {2'd1, 2'd2, 4'd1});
      @(posedge clk); #1;
      check("ovr pulse width", overrun, 0);
      check("ovr still valid", out_valid, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("ovr drop after ready", out_valid, 0);
      check("ovr pulse count", cnt_ovr - o0, 1);
      idle(3);

      // new frame completes in the very cycle the held frame is consumed
      out_ready = 1'b0;
      o0 = cnt_ovr;
      build_frame(2'd1, 2'd0, 4'd2, 128'hA1B2C3, -1);
      send_all();
      @(posedge clk); #1;
      check("swap first out_valid", out_valid, 1);
      build_frame(2'd3, 2'd1, 4'd1, 128'h55AA, -1);
      send_range(0, fq.size() - 2);
      @(negedge clk);
      rx_line   = fq[fq.size() - 1];
      out_ready = 1'b1;
      @(posedge clk); #1;
      rx_line = 1'b0;
      check("swap out_valid kept", out_valid, 1);
      check("swap new payload", out_payload, 128'h55AA);
      check("swap new dest/src/len", {out_dest, out_src, out_len}, {2'd3, 2'd1, 4'd1});
      check("swap no overrun", cnt_ovr - o0, 0);
      @(posedge clk); #1;
      check("swap consumed", out_valid, 0);
      idle(3);

      // garbage, truncated preamble, preamble with bad SFD, then a max-length frame
      c0 = cnt_crc;
      f0 = cnt_filt;
      fq.delete();
      push_pat(16'h00AA, 8);
      push_pat(16'h0003, 4);
      push_pat(16'hAAAA, 16);
      push_pat(16'h0000, 8);
      push_pat(16'h000C, 4);
      send_all();
      @(posedge clk); #1;
      check("garbage out_valid", out_valid, 0);
      check("garbage pulses", (cnt_crc - c0) + (cnt_filt - f0), 0);
      rpay = {$urandom, $urandom, $urandom, $urandom};
      build_frame(2'd1, 2'd3, 4'd15, rpay, -1);
      send_all();
      @(posedge clk); #1;
      rx_line = 1'b0;
      check("rand16 out_valid", out_valid, 1);
      check("rand16 out_payload", out_payload, rpay);
      check("rand16 dest/src/len", {out_dest, out_src, out_len}, {2'd1, 2'd3, 4'd15});
      @(posedge clk); #1;
      check("rand16 consumed", out_valid, 0);
      idle(3);

      // asynchronous reset in the middle of a payload
      out_ready = 1'b0;
      build_frame(2'd1, 2'd2, 4'd0, 128'h77, -1);
      send_all();
      @(posedge clk); #1;
      check("prerst out_valid", out_valid, 1);
      c0 = cnt_crc;
      f0 = cnt_filt;
      o0 = cnt_ovr;
      build_frame(2'd1, 2'd1, 4'd15, 128'hFFFF0000FFFF0000_0F0F0F0F0F0F0F0F, -1);
      send_range(0, 16 + 8 + 8 + 40 - 1);
      @(negedge clk);
      rst_n   = 1'b0;
      rx_line = 1'b0;
      #1;
      check("rst out_valid", out_valid, 0);
      check("rst out_payload", out_payload, 0);
      check("rst dest/src/len", {out_dest, out_src, out_len}, 0);
      check("rst pulses", {crc_err, overrun, filtered}, 0);
      repeat (2) @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      idle(3);
      build_frame(2'd1, 2'd3, 4'd2, 128'h0F1E2D, -1);
      send_all();
      @(posedge clk); #1;
      rx_line = 1'b0;
      check("postrst out_valid", out_valid, 1);
      check("postrst out_payload", out_payload, 128'h0F1E2D);
      check("postrst dest/src/len", {out_dest, out_src, out_len}, {2'd1, 2'd3, 4'd2});
      check("postrst no pulses", (cnt_crc - c0) + (cnt_filt - f0) + (cnt_ovr - o0), 0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
